uart_proc: RTL and testbench

//  Byte-level command processor behind a UART. Parses framed register write/read

---
 rtl/uart_proc.sv | 274 +++++++++++++++++++++++++++
 tb/tb_uart_proc.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_proc.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : uart_proc
// Purpose  : Byte-level command processor sitting between a UART byte
//            interface and a 12-bit register bus. Parses framed single/burst
//            register write and read commands, issues register writes,
//            returns read data followed by a CRC-16-CCITT of the frame.
// Ports    : clk, rst (async, active-low)
//            cmd_req/cmd_data/cmd_ack  - RX byte 4-phase handshake (in)
//            rsp_req/rsp_data/rsp_ack  - TX byte 4-phase handshake (out)
//            adr/wr_data/wr/rd_data    - register bus
//            err_req/err_ack           - sticky CRC/format error flag
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module uart_proc #(
  parameter int TIMEOUT = 1000,
  parameter int RD_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_req,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ack,
  output logic        rsp_req,
  output logic [7:0]  rsp_data,
  input  logic        rsp_ack,
  output logic [11:0] adr,
  output logic [15:0] wr_data,
  output logic        wr,
  input  logic [15:0] rd_data,
  output logic        err_req,
  input  logic        err_ack
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [4:0] {
    S_HDR1, S_HDR0, S_PID1, S_PID0, S_LEN1, S_LEN0, S_ADR1, S_ADR0,
    S_WD1, S_WD0, S_WCRC1, S_WCRC0,
    S_RD_WAIT, S_RD1, S_RD0, S_RCRC1, S_RCRC0
  } state_t;

  state_t          state;
  logic [15:0]     crc;
  logic [7:0]      byte_hi;   // first byte of the current 16-bit field
  logic            is_read;
  logic [15:0]     cnt;       // words still to transfer, including current
  logic [11:0]     nxt_adr;
  logic [15:0]     rd_word;
  logic [TW-1:0]   timer;
  logic [LW-1:0]   lat;

  // One CRC-16-CCITT step (poly 0x1021, MSB first) over a byte.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic        rx_state;
  logic        accept;
  logic [15:0] word_rx;
  logic [15:0] crc_rx;
  logic [15:0] crc_rd_hi;
  logic [15:0] crc_rd_lo;
  logic        rsp_idle;
  logic        rsp_taken;
  logic        lat_done;
  logic        timer_exp;

  // Bytes are only taken in receive states; while transmitting cmd_req is ignored.
  assign rx_state  = state inside {S_HDR1, S_HDR0, S_PID1, S_PID0, S_LEN1, S_LEN0,
                                   S_ADR1, S_ADR0, S_WD1, S_WD0, S_WCRC1, S_WCRC0};
  assign accept    = cmd_req & ~cmd_ack & rx_state;
  assign word_rx   = {byte_hi, cmd_data};
  assign crc_rx    = crc_upd(crc, cmd_data);
  assign crc_rd_hi = crc_upd(crc, rd_data[15:8]);
  assign crc_rd_lo = crc_upd(crc, rd_word[7:0]);
  assign rsp_idle  = ~rsp_req & ~rsp_ack;
  assign rsp_taken = rsp_req & rsp_ack;
  assign lat_done  = (lat == LW'(RD_LAT - 1));
  assign timer_exp = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_HDR1;
      crc      <= 16'hFFFF;
      byte_hi  <= 8'h00;
      is_read  <= 1'b0;
      cnt      <= 16'h0000;
      nxt_adr  <= 12'h000;
      rd_word  <= 16'h0000;
      timer    <= '0;
      lat      <= '0;
      cmd_ack  <= 1'b0;
      rsp_req  <= 1'b0;
      rsp_data <= 8'h00;
      adr      <= 12'h000;
      wr_data  <= 16'h0000;
      wr       <= 1'b0;
      err_req  <= 1'b0;
    end else begin
      wr <= 1'b0;
      // Cleared here; an error raised later in this block overrides the clear.
      if (err_ack) err_req <= 1'b0;

      if (accept)                 cmd_ack <= 1'b1;
      else if (cmd_ack && !cmd_req) cmd_ack <= 1'b0;

      if (accept || !rx_state || state == S_HDR1) timer <= '0;
      else                                        timer <= timer + 1'b1;

      if (rx_state && state != S_HDR1 && !accept && timer_exp) begin
        state <= S_HDR1;
        crc   <= 16'hFFFF;
      end else begin
        case (state)
          S_HDR1: if (accept) begin
            if (cmd_data == 8'h8F) begin
              crc   <= crc_rx;
              state <= S_HDR0;
            end else begin
              crc <= 16'hFFFF;
            end
          end
          S_HDR0: if (accept) begin
            if (cmd_data == 8'hC7) begin
              crc   <= crc_rx;
              state <= S_PID1;
            end else begin
              crc   <= 16'hFFFF;
              state <= S_HDR1;
            end
          end
          S_PID1: if (accept) begin
            byte_hi <= cmd_data;
            crc     <= crc_rx;
            state   <= S_PID0;
          end
          S_PID0: if (accept) begin
            if (word_rx[14:0] == 15'd1 || word_rx[14:0] == 15'd2) begin
              crc     <= crc_rx;
              is_read <= (word_rx[14:0] == 15'd2);
              cnt     <= 16'd1;
              state   <= word_rx[15] ? S_LEN1 : S_ADR1;
            end else begin
              err_req <= 1'b1;
              crc     <= 16'hFFFF;
              state   <= S_HDR1;
            end
          end
          S_LEN1: if (accept) begin
            byte_hi <= cmd_data;
            crc     <= crc_rx;
            state   <= S_LEN0;
          end
          S_LEN0: if (accept) begin
            if (word_rx == 16'h0000) begin
              err_req <= 1'b1;
              crc     <= 16'hFFFF;
              state   <= S_HDR1;
            end else begin
              cnt   <= word_rx;
              crc   <= crc_rx;
              state <= S_ADR1;
            end
          end
          S_ADR1: if (accept) begin
            byte_hi <= cmd_data;
            crc     <= crc_rx;
            state   <= S_ADR0;
          end
          S_ADR0: if (accept) begin
            crc <= crc_rx;
            if (is_read) begin
              // Reads present the first address right away; writes wait for data.
              adr     <= word_rx[11:0];
              nxt_adr <= word_rx[11:0] + 12'd1;
              lat     <= '0;
              state   <= S_RD_WAIT;
            end else begin
              nxt_adr <= word_rx[11:0];
              state   <= S_WD1;
            end
          end
          S_WD1: if (accept) begin
            byte_hi <= cmd_data;
            crc     <= crc_rx;
            state   <= S_WD0;
          end
          S_WD0: if (accept) begin
            crc     <= crc_rx;
            wr      <= 1'b1;
            wr_data <= word_rx;
            adr     <= nxt_adr;
            nxt_adr <= nxt_adr + 12'd1;
            cnt     <= cnt - 16'd1;
            state   <= (cnt == 16'd1) ? S_WCRC1 : S_WD1;
          end
          S_WCRC1: if (accept) begin
            byte_hi <= cmd_data;
            state   <= S_WCRC0;
          end
          S_WCRC0: if (accept) begin
            if (word_rx != crc) err_req <= 1'b1;
            crc   <= 16'hFFFF;
            state <= S_HDR1;
          end
          S_RD_WAIT: begin
            if (lat_done) begin
              rd_word  <= rd_data;
              rsp_data <= rd_data[15:8];
              rsp_req  <= 1'b1;
              crc      <= crc_rd_hi;
              state    <= S_RD1;
            end else begin
              lat <= lat + 1'b1;
            end
          end
          S_RD1: begin
            if (rsp_taken) rsp_req <= 1'b0;
            else if (rsp_idle) begin
              rsp_data <= rd_word[7:0];
              rsp_req  <= 1'b1;
              crc      <= crc_rd_lo;
              state    <= S_RD0;
            end
          end
          S_RD0: begin
            if (rsp_taken) rsp_req <= 1'b0;
            else if (rsp_idle) begin
              if (cnt == 16'd1) begin
                rsp_data <= crc[15:8];
                rsp_req  <= 1'b1;
                state    <= S_RCRC1;
              end else begin
                cnt     <= cnt - 16'd1;
                adr     <= nxt_adr;
                nxt_adr <= nxt_adr + 12'd1;
                lat     <= '0;
                state   <= S_RD_WAIT;
              end
            end
          end
          S_RCRC1: begin
            if (rsp_taken) rsp_req <= 1'b0;
            else if (rsp_idle) begin
              rsp_data <= crc[7:0];
              rsp_req  <= 1'b1;
              state    <= S_RCRC0;
            end
          end
          S_RCRC0: begin
            if (rsp_taken) rsp_req <= 1'b0;
            else if (rsp_idle) begin
              crc   <= 16'hFFFF;
              state <= S_HDR1;
            end
          end
          default: begin
            crc   <= 16'hFFFF;
            state <= S_HDR1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_proc.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : tb_uart_proc
// Purpose  : Randomised scoreboard bench for uart_proc. Frames are built from
//            a byte-level reference model; expected register writes and TX
//            bytes are queued and popped by independent monitors.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_uart_proc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_req = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_ack;
  logic        rsp_req;
  logic [7:0]  rsp_data;
  logic        rsp_ack = 1'b0;
  logic [11:0] adr;
  logic [15:0] wr_data;
  logic        wr;
  logic [15:0] rd_data;
  logic        err_req;
  logic        err_ack = 1'b0;

  always #5 clk = ~clk;

  uart_proc #(.TIMEOUT(1000), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_req(cmd_req), .cmd_data(cmd_data), .cmd_ack(cmd_ack),
    .rsp_req(rsp_req), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
    .adr(adr), .wr_data(wr_data), .wr(wr), .rd_data(rd_data),
    .err_req(err_req), .err_ack(err_ack)
  );

  // Register file model seen by the read port.
  logic [15:0] mem [0:4095];
  assign rd_data = mem[adr];

  int checks = 0;
  int passes = 0;
  logic [7:0]  exp_rsp[$];
  logic [27:0] exp_wr[$];
  logic [15:0] wdata [0:63];
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference CRC: shift each message bit into the register, MSB first.
  function automatic logic [15:0] model_crc(input logic [7:0] q[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (q[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ q[i][k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic wait_ack(input logic v);
    int n;
    n = 0;
    while (cmd_ack !== v && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("cmd_ack_wait", 32'(cmd_ack), 32'(v));
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ack(1'b0);
    cmd_data = b;
    cmd_req  = 1'b1;
    wait_ack(1'b1);
    cmd_req  = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || exp_wr.size() != 0) && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_rsp_left", exp_rsp.size(), 0);
    check("drain_wr_left", exp_wr.size(), 0);
  endtask

  task automatic clear_err();
    @(posedge clk); #1 err_ack = 1'b1;
    @(posedge clk); #1 err_ack = 1'b0;
    check("err_cleared", 32'(err_req), 0);
  endtask

  // Build a frame from the protocol rules, queue the expected bus/TX activity,
  // send it and compare the error flag.
  task automatic run_frame(input bit rd, input bit burst, input int n,
                           input logic [15:0] adr_field, input bit corrupt);
    logic [7:0]  f[$];
    logic [7:0]  g[$];
    logic [15:0] c;
    logic [15:0] pid;
    logic [11:0] ai;
    logic [15:0] d;
    pid = {burst, 13'd0, rd ? 2'd2 : 2'd1};
    f = {8'h8F, 8'hC7, pid[15:8], pid[7:0]};
    if (burst) begin
      f.push_back(8'((n >> 8) & 255));
      f.push_back(8'(n & 255));
    end
    f.push_back(adr_field[15:8]);
    f.push_back(adr_field[7:0]);
    if (!rd) begin
      for (int i = 0; i < n; i++) begin
        ai = adr_field[11:0] + 12'(i);
        f.push_back(wdata[i][15:8]);
        f.push_back(wdata[i][7:0]);
        exp_wr.push_back({ai, wdata[i]});
      end
      c = model_crc(f);
      f.push_back(c[15:8]);
      f.push_back(c[7:0] ^ {7'd0, corrupt});
    end else begin
      g = f;
      for (int i = 0; i < n; i++) begin
        ai = adr_field[11:0] + 12'(i);
        d  = mem[ai];
        g.push_back(d[15:8]);
        g.push_back(d[7:0]);
        exp_rsp.push_back(d[15:8]);
        exp_rsp.push_back(d[7:0]);
      end
      c = model_crc(g);
      exp_rsp.push_back(c[15:8]);
      exp_rsp.push_back(c[7:0]);
    end
    send_bytes(f);
    drain();
    check(rd ? "rd_err_flag" : "wr_err_flag", 32'(err_req), 32'(corrupt));
  endtask

  // Write-bus monitor.
  initial begin
    logic [27:0] e;
    forever begin
      @(posedge clk); #1;
      if (mon_en && wr) begin
        check("wr_expected", 32'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          check("wr_adr_data", {4'h0, adr, wr_data}, {4'h0, e});
        end
      end
    end
  end

  // TX-side monitor: acts as the UART transmitter with random ack delays.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk); #1;
      if (mon_en && rsp_req && !rsp_ack) begin
        check("rsp_expected", 32'(exp_rsp.size() > 0), 1);
        if (exp_rsp.size() > 0) begin
          e = exp_rsp.pop_front();
          check("rsp_byte", 32'(rsp_data), 32'(e));
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 rsp_ack = 1'b1;
      end else if (!rsp_req && rsp_ack) begin
        rsp_ack = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [15:0] af;
    logic [7:0] junk;
    bit rdb;
    bit bb;
    int n;

    for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 7 + 3);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {2'b0, cmd_ack, rsp_req, rsp_data, adr, wr_data, wr, err_req},
          32'h0);
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single write.
    wdata[0] = 16'hDEF1;
    run_frame(1'b0, 1'b0, 1, 16'h0ABC, 1'b0);

    // Single read.
    mem[12'hABC] = 16'hDEED;
    run_frame(1'b1, 1'b0, 1, 16'h0ABC, 1'b0);
    check("single_rd_adr", 32'(adr), 32'h0ABC);

    // Burst write of 16 words.
    for (int i = 0; i < 16; i++) wdata[i] = {8'(15 - i), 8'(i)};
    run_frame(1'b0, 1'b1, 16, 16'h0ABC, 1'b0);
    check("burst_wr_last_adr", 32'(adr), 32'h0ACB);

    // Burst read of 16 words, data incrementing per word.
    for (int i = 0; i < 16; i++) mem[12'hABC + 12'(i)] = 16'h1000 + 16'(i);
    run_frame(1'b1, 1'b1, 16, 16'h0ABC, 1'b0);

    // Partial frame then idle: parser must return to HDR1.
    q = {8'h8F, 8'hC7, 8'h80, 8'h02, 8'h00};
    send_bytes(q);
    repeat (1100) @(posedge clk);
    #1;
    check("timeout_no_err", 32'(err_req), 0);
    wdata[0] = 16'h5A5A;
    run_frame(1'b0, 1'b0, 1, 16'h0123, 1'b0);

    // Corrupted CRC: write still happens, error is sticky until acked.
    wdata[0] = 16'h7777;
    run_frame(1'b0, 1'b0, 1, 16'h0200, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("err_sticky", 32'(err_req), 1);
    clear_err();
    wdata[0] = 16'h8888;
    run_frame(1'b0, 1'b0, 1, 16'h0201, 1'b0);

    // Unknown PID and zero length raise the error flag.
    q = {8'h8F, 8'hC7, 8'h00, 8'h05};
    send_bytes(q);
    check("bad_pid_err", 32'(err_req), 1);
    clear_err();
    q = {8'h8F, 8'hC7, 8'h80, 8'h01, 8'h00, 8'h00};
    send_bytes(q);
    check("len0_err", 32'(err_req), 1);
    clear_err();

    // Burst wrapping past 0xFFF, with garbage ahead of the header.
    send_byte(8'h12);
    for (int i = 0; i < 4; i++) wdata[i] = 16'hC000 + 16'(i);
    run_frame(1'b0, 1'b1, 4, 16'hFFFE, 1'b0);

    // Asynchronous reset in the middle of a burst write.
    exp_wr.push_back({12'h100, 16'h1234});
    q = {8'h8F, 8'hC7, 8'h80, 8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h12, 8'h34};
    send_bytes(q);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_reset_outputs", {4'h0, adr, wr_data}, 32'h0);
    #20 rst = 1'b1;
    @(posedge clk); #1;
    wdata[0] = 16'h4321;
    run_frame(1'b0, 1'b0, 1, 16'h0321, 1'b0);

    // Randomised frames.
    for (int t = 0; t < 24; t++) begin
      rdb = 1'($urandom_range(0, 1));
      bb  = 1'($urandom_range(0, 1));
      n   = bb ? int'($urandom_range(1, 6)) : 1;
      af  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) af[11:0] = 12'hFFD;
      for (int i = 0; i < n; i++) begin
        wdata[i] = 16'($urandom);
        mem[af[11:0] + 12'(i)] = 16'($urandom);
      end
      if ($urandom_range(0, 4) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'h8F) junk = 8'h00;
        send_byte(junk);
      end
      run_frame(rdb, bb, n, af, 1'b0);
    end

    repeat (10) @(posedge clk);
    #1;
    check("final_rsp_queue", exp_rsp.size(), 0);
    check("final_wr_queue", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
